vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE_AREA, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT_PORCH / H_SYNC_PULSE / H_BACK_PORCH, defaults 16 / 96 / 48, horizontal blanking segments in pixels.
REQ-003 SHALL have parameters V_VISIBLE_AREA / V_FRONT_PORCH / V_SYNC_PULSE / V_BACK_PORCH, defaults 480 / 10 / 2 / 33, vertical segments in lines.
REQ-004 SHALL have parameters H_SYNC_POL / V_SYNC_POL, default 0, sync active level (0 = active-low).
REQ-005 SHALL have parameter PIX_DIV, default 1, range 1..16, clk cycles per pixel.
REQ-006 SHALL have parameter OUT_DELAY, default 0, range 0..4, extra register stages on hsync/vsync/display_enabled.
REQ-007 SHALL derive H_WHOLE_LINE/V_WHOLE_LINE as segment sums; H_ADDR_WIDTH/V_ADDR_WIDTH = $clog2 of those.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 en  in  1  advance enable; low freezes counters and strobes.
REQ-011 sx  out  H_ADDR_WIDTH  current pixel column.
REQ-012 sy  out  V_ADDR_WIDTH  current line.
REQ-013 display_enabled  out  1  high inside visible area (after OUT_DELAY).
REQ-014 hsync / vsync  out  1 each  sync pulses at configured polarity (after OUT_DELAY).
REQ-015 pix_stb  out  1  one-cycle pulse per pixel advance.
REQ-016 line_stb / frame_stb  out  1 each  one-cycle pulse on pix_stb where sx==0 (line) / sx==0 and sy==0 (frame).

Function
REQ-017 SHALL run a divider counter 0..PIX_DIV-1 while en=1; pix_stb high when divider==PIX_DIV-1 and en=1; PIX_DIV=1 gives pix_stb=en.
REQ-018 On pix_stb, sx SHALL increment; at sx==H_WHOLE_LINE-1 wrap to 0 and increment sy; at sy==V_WHOLE_LINE-1 with sx wrap, sy wraps to 0.
REQ-019 display_enabled (undelayed) SHALL = (sx < H_VISIBLE_AREA) and (sy < V_VISIBLE_AREA).
REQ-020 hsync SHALL be active for sx in [HVIS+HFP, HVIS+HFP+HSP-1], else inactive; vsync likewise for sy in [VVIS+VFP, VVIS+VFP+VSP-1], independent of sx.
REQ-021 Timing outputs SHALL be combinational from counters when OUT_DELAY=0, else pass through exactly OUT_DELAY clk-cycle registers; sx, sy and strobes are never delayed.
REQ-022 en=0 SHALL hold divider, sx, sy; strobes 0; delay pipeline continues shifting held values.
REQ-023 Counter arithmetic SHALL never exceed WHOLE_LINE-1; no out-of-range value reachable.

Reset
REQ-024 rst=1 SHALL set divider, sx, sy to 0, strobes to 0, all delay stages to display_enabled=0 and hsync/vsync inactive; dominates en.
REQ-025 rst asserted mid-frame SHALL restart at sx=0, sy=0; first pix_stb after release asserts line_stb and frame_stb together.

Configuration
REQ-026 Macro VGA_TEST_PATTERN_EN defined: SHALL add outputs R, G, B (4 bits each) giving 8 equal vertical colour bars (bar index = sx*8/H_VISIBLE_AREA, colour bits {B,G,R} = index, each bit expands to 4'hF), zero when display_enabled low, aligned to display_enabled.
REQ-027 Macro undefined: R, G, B ports and pattern logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Defaults, en=1, release rst: frame_stb period 420000 clk; line_stb period 800 clk; display_enabled high 640 cycles per visible line.
REQ-029 Defaults: hsync low exactly at sx 656..751; vsync low exactly for sy 490..491; H_SYNC_POL=1 inverts both windows' level only.
REQ-030 PIX_DIV=4: pix_stb every 4th clk; line_stb period 3200 clk; sx stable 4 cycles each.
REQ-031 OUT_DELAY=2: hsync falling edge 2 clk after sx becomes 656; sx/line_stb unshifted.
REQ-032 Pulse rst at sx=300, sy=200 -> next cycle sx=0, sy=0, hsync/vsync inactive; first pix_stb after release coincides with frame_stb.
REQ-033 en low 50 cycles at sx=799, sy=524 -> counters held, no strobes; on en high wrap to 0,0 with frame_stb; with VGA_TEST_PATTERN_EN, sx=0..79 R=G=B=0, sx=80..159 R=F.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
//
// Purpose: divides clk down to a pixel rate and scans a pixel column (sx) and
// line (sy) counter over the whole frame. From these counters it derives
// display_enabled and the hsync/vsync pulses, with an optional register
// delay, plus per-pixel, per-line and per-frame strobes.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset, dominates en
//   en               advance enable; low freezes counters and strobes
//   sx, sy           current pixel column / line (never delayed)
//   display_enabled  high inside the visible area (OUT_DELAY cycles late)
//   hsync, vsync     sync pulses at H_SYNC_POL / V_SYNC_POL (OUT_DELAY late)
//   pix_stb          one-cycle pulse per pixel advance
//   line_stb         pix_stb where sx == 0
//   frame_stb        pix_stb where sx == 0 and sy == 0
//   R, G, B          4-bit colour-bar test pattern, aligned to display_enabled
//                    (present only when VGA_TEST_PATTERN_EN is defined)
//
// Build option: define VGA_TEST_PATTERN_EN to add the R/G/B test pattern.

module vga_timing_gen #(
   parameter int  H_VISIBLE_AREA = 640,
   parameter int  H_FRONT_PORCH  = 16,
   parameter int  H_SYNC_PULSE   = 96,
   parameter int  H_BACK_PORCH   = 48,
   parameter int  V_VISIBLE_AREA = 480,
   parameter int  V_FRONT_PORCH  = 10,
   parameter int  V_SYNC_PULSE   = 2,
   parameter int  V_BACK_PORCH   = 33,
   parameter bit  H_SYNC_POL     = 1'b0,
   parameter bit  V_SYNC_POL     = 1'b0,
   parameter int  PIX_DIV        = 1,
   parameter int  OUT_DELAY      = 0,
   localparam int H_WHOLE_LINE   = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
   localparam int V_WHOLE_LINE   = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
   localparam int H_ADDR_WIDTH   = $clog2(H_WHOLE_LINE),
   localparam int V_ADDR_WIDTH   = $clog2(V_WHOLE_LINE)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   output logic [H_ADDR_WIDTH-1:0] sx,
   output logic [V_ADDR_WIDTH-1:0] sy,
   output logic                    display_enabled,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    pix_stb,
   output logic                    line_stb,
   output logic                    frame_stb
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [3:0]              R,
   output logic [3:0]              G,
   output logic [3:0]              B
`endif
);

   // PIX_DIV = 1 still needs a 1-bit divider register; it simply stays 0.
   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0]        DIV_MAX  = DIV_W'(PIX_DIV - 1);
   localparam logic [H_ADDR_WIDTH-1:0] SX_MAX   = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
   localparam logic [V_ADDR_WIDTH-1:0] SY_MAX   = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);
   localparam logic [H_ADDR_WIDTH-1:0] SX_VIS   = H_ADDR_WIDTH'(H_VISIBLE_AREA);
   localparam logic [V_ADDR_WIDTH-1:0] SY_VIS   = V_ADDR_WIDTH'(V_VISIBLE_AREA);
   localparam logic [H_ADDR_WIDTH-1:0] HS_FIRST = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH);
   localparam logic [H_ADDR_WIDTH-1:0] HS_LAST  = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE - 1);
   localparam logic [V_ADDR_WIDTH-1:0] VS_FIRST = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH);
   localparam logic [V_ADDR_WIDTH-1:0] VS_LAST  = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE - 1);

`ifdef VGA_TEST_PATTERN_EN
   localparam int TW = 15;
   localparam logic [TW-1:0] TIM_IDLE = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL, 12'h000};
`else
   localparam int TW = 3;
   localparam logic [TW-1:0] TIM_IDLE = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL};
`endif

   logic [DIV_W-1:0]        div_q, div_d;
   logic [H_ADDR_WIDTH-1:0] sx_q, sx_d;
   logic [V_ADDR_WIDTH-1:0] sy_q, sy_d;
   logic                    pix_adv;
   logic                    de_u, hs_act, vs_act;
   logic [TW-1:0]           tim_u, tim_o;

   // Counters: the divider free-runs while enabled; sx/sy move only on a
   // pixel advance and wrap exactly at the last column / line.
   always_comb begin
      pix_adv = en && !rst && (div_q == DIV_MAX);
      div_d   = div_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      if (en) begin
         div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      end
      if (pix_adv) begin
         if (sx_q == SX_MAX) begin
            sx_d = '0;
            sy_d = (sy_q == SY_MAX) ? '0 : sy_q + 1'b1;
         end else begin
            sx_d = sx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         sx_q  <= '0;
         sy_q  <= '0;
      end else begin
         div_q <= div_d;
         sx_q  <= sx_d;
         sy_q  <= sy_d;
      end
   end

   assign sx        = sx_q;
   assign sy        = sy_q;
   assign pix_stb   = pix_adv;
   assign line_stb  = pix_adv && (sx_q == '0);
   assign frame_stb = pix_adv && (sx_q == '0) && (sy_q == '0);

   always_comb begin
      de_u   = (sx_q < SX_VIS) && (sy_q < SY_VIS);
      hs_act = (sx_q >= HS_FIRST) && (sx_q <= HS_LAST);
      vs_act = (sy_q >= VS_FIRST) && (sy_q <= VS_LAST);
   end

`ifdef VGA_TEST_PATTERN_EN
   // Eight equal bars across the visible width: bar = sx*8 / H_VISIBLE_AREA.
   localparam logic [H_ADDR_WIDTH+2:0] BAR_DIV = (H_ADDR_WIDTH + 3)'(H_VISIBLE_AREA);
   logic [H_ADDR_WIDTH+2:0] sx_x8;
   logic [2:0]              bar;
   logic [11:0]             rgb_u;

   always_comb begin
      sx_x8 = {sx_q, 3'b000};
      bar   = 3'(sx_x8 / BAR_DIV);
      rgb_u = de_u ? {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}} : 12'h000;
      tim_u = {de_u, hs_act ? H_SYNC_POL : ~H_SYNC_POL,
               vs_act ? V_SYNC_POL : ~V_SYNC_POL, rgb_u};
   end
`else
   always_comb begin
      tim_u = {de_u, hs_act ? H_SYNC_POL : ~H_SYNC_POL,
               vs_act ? V_SYNC_POL : ~V_SYNC_POL};
   end
`endif

   // Timing outputs share one delay line so the pattern stays aligned with
   // display_enabled. The line keeps shifting while en is low.
   generate
      if (OUT_DELAY == 0) begin : g_nodly
         assign tim_o = tim_u;
      end else begin : g_dly
         logic [TW-1:0] pipe_q [OUT_DELAY];
         logic [TW-1:0] pipe_d [OUT_DELAY];

         always_comb begin
            pipe_d[0] = tim_u;
            for (int i = 1; i < OUT_DELAY; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            for (int i = 0; i < OUT_DELAY; i++) begin
               pipe_q[i] <= rst ? TIM_IDLE : pipe_d[i];
            end
         end

         assign tim_o = pipe_q[OUT_DELAY-1];
      end
   endgenerate

`ifdef VGA_TEST_PATTERN_EN
   assign {display_enabled, hsync, vsync, R, G, B} = tim_o;
`else
   assign {display_enabled, hsync, vsync} = tim_o;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- self-checking bench for vga_timing_gen.
// dut_a: default 640x480 timing. dut_b: small 15x8 frame, PIX_DIV=4,
// OUT_DELAY=2, active-high syncs, so whole frames fit in a short run.
// Both DUTs share clk/rst/en. A model derives every expected output from the
// count of enabled cycles since reset; expectations are queued when the
// inputs are driven and popped when the outputs are sampled.

module tb_vga_timing_gen;

   logic       clk, rst, en;
   logic [9:0] sx_a, sy_a;
   logic       de_a, hs_a, vs_a, pix_a, line_a, frame_a;
   logic [3:0] sx_b;
   logic [2:0] sy_b;
   logic       de_b, hs_b, vs_b, pix_b, line_b, frame_b;
   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

`ifdef VGA_TEST_PATTERN_EN
   localparam bit PAT_ON = 1'b1;
`else
   localparam bit PAT_ON = 1'b0;
   assign r_a = 4'h0;
   assign g_a = 4'h0;
   assign b_a = 4'h0;
   assign r_b = 4'h0;
   assign g_b = 4'h0;
   assign b_b = 4'h0;
`endif

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst), .en(en), .sx(sx_a), .sy(sy_a),
      .display_enabled(de_a), .hsync(hs_a), .vsync(vs_a),
      .pix_stb(pix_a), .line_stb(line_a), .frame_stb(frame_a)
`ifdef VGA_TEST_PATTERN_EN
      , .R(r_a), .G(g_a), .B(b_a)
`endif
   );

   vga_timing_gen #(
      .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
      .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(4), .OUT_DELAY(2)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .sx(sx_b), .sy(sy_b),
      .display_enabled(de_b), .hsync(hs_b), .vsync(vs_b),
      .pix_stb(pix_b), .line_stb(line_b), .frame_stb(frame_b)
`ifdef VGA_TEST_PATTERN_EN
      , .R(r_b), .G(g_b), .B(b_b)
`endif
   );

   typedef struct packed {
      logic [9:0] sx; logic [9:0] sy;
      logic pix, line, frame, de, hs, vs;
      logic [3:0] r, g, b;
   } obs_a_t;
   typedef struct packed {
      logic [3:0] sx; logic [2:0] sy;
      logic pix, line, frame, de, hs, vs;
      logic [3:0] r, g, b;
   } obs_b_t;
   typedef struct packed { obs_a_t a; obs_b_t b; } obs_t;
   typedef struct packed { logic de, hs, vs; logic [3:0] r, g, b; } tim_t;

   obs_t exp_q[$];
   tim_t hist_b[$];
   tim_t cur_ub;
   int   n;
   int   chk_cnt, pass_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected outputs for the current cycle, from n (enabled cycles since reset)
   // and the inputs applied in this cycle.
   function automatic obs_t model(input bit r, input bit e);
      obs_t m;
      int   x, y, p;
      x = n % 800;
      y = (n / 800) % 525;
      m.a.sx    = 10'(x);
      m.a.sy    = 10'(y);
      m.a.pix   = e && !r;
      m.a.line  = m.a.pix && (x == 0);
      m.a.frame = m.a.line && (y == 0);
      m.a.de    = (x < 640) && (y < 480);
      m.a.hs    = !((x >= 656) && (x <= 751));
      m.a.vs    = !((y >= 490) && (y <= 491));
      m.a.r     = (PAT_ON && m.a.de && ((x / 80) % 2 == 1)) ? 4'hF : 4'h0;
      m.a.g     = (PAT_ON && m.a.de && ((x / 160) % 2 == 1)) ? 4'hF : 4'h0;
      m.a.b     = (PAT_ON && m.a.de && ((x / 320) % 2 == 1)) ? 4'hF : 4'h0;
      p = n / 4;
      x = p % 15;
      y = (p / 15) % 8;
      m.b.sx    = 4'(x);
      m.b.sy    = 3'(y);
      m.b.pix   = e && !r && (n % 4 == 3);
      m.b.line  = m.b.pix && (x == 0);
      m.b.frame = m.b.line && (y == 0);
      cur_ub.de = (x < 8) && (y < 4);
      cur_ub.hs = (x >= 10) && (x <= 12);
      cur_ub.vs = (y >= 5) && (y <= 6);
      cur_ub.r  = (PAT_ON && cur_ub.de && (x % 2 == 1)) ? 4'hF : 4'h0;
      cur_ub.g  = (PAT_ON && cur_ub.de && ((x / 2) % 2 == 1)) ? 4'hF : 4'h0;
      cur_ub.b  = (PAT_ON && cur_ub.de && ((x / 4) % 2 == 1)) ? 4'hF : 4'h0;
      m.b.de = hist_b[0].de;
      m.b.hs = hist_b[0].hs;
      m.b.vs = hist_b[0].vs;
      m.b.r  = hist_b[0].r;
      m.b.g  = hist_b[0].g;
      m.b.b  = hist_b[0].b;
      return m;
   endfunction

   // Entered at a falling edge: drive, queue expectation, sample, clock.
   task automatic drive_cycle(input bit r, input bit e, output obs_t act);
      tim_t tmp;
      rst = r;
      en  = e;
      exp_q.push_back(model(r, e));
      #1;
      act.a = {sx_a, sy_a, pix_a, line_a, frame_a, de_a, hs_a, vs_a, r_a, g_a, b_a};
      act.b = {sx_b, sy_b, pix_b, line_b, frame_b, de_b, hs_b, vs_b, r_b, g_b, b_b};
      @(posedge clk);
      if (r) begin
         n = 0;
         hist_b = {};
         hist_b.push_back('0);
         hist_b.push_back('0);
      end else begin
         if (e) n++;
         hist_b.push_back(cur_ub);
         tmp = hist_b.pop_front();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t act, ex;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b1, act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act.a !== ex.a) $display("FAIL reset_a cyc %0d got %h expected %h", i, act.a, ex.a); else pass_cnt++;
         chk_cnt++;
         if (act.b !== ex.b) $display("FAIL reset_b cyc %0d got %h expected %h", i, act.b, ex.b); else pass_cnt++;
      end
      chk_cnt++;
      if ({act.b.sx, act.b.sy, act.b.de, act.b.hs, act.b.vs} !== 10'b0)
         $display("FAIL reset_b_idle got %b expected 0", {act.b.sx, act.b.sy, act.b.de, act.b.hs, act.b.vs});
      else pass_cnt++;
      chk_cnt++;
      if ({act.a.pix, act.a.line, act.a.frame, act.b.pix} !== 4'b0)
         $display("FAIL reset_strobes got %b expected 0000", {act.a.pix, act.a.line, act.a.frame, act.b.pix});
      else pass_cnt++;
   endtask

   task automatic test_line_timing();
      obs_t act, ex;
      int last_line = -1, de_cnt = 0, hs_cnt = 0, lines = 0;
      for (int i = 0; i < 2500; i++) begin
         drive_cycle(1'b0, 1'b1, act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act.a !== ex.a) $display("FAIL line_a cyc %0d got %h expected %h", i, act.a, ex.a); else pass_cnt++;
         if (act.a.line) begin
            lines++;
            if (last_line >= 0) begin
               chk_cnt++;
               if (i - last_line !== 800) $display("FAIL line_period got %0d expected 800", i - last_line); else pass_cnt++;
               chk_cnt++;
               if (de_cnt !== 640) $display("FAIL de_per_line got %0d expected 640", de_cnt); else pass_cnt++;
               chk_cnt++;
               if (hs_cnt !== 96) $display("FAIL hsync_low_per_line got %0d expected 96", hs_cnt); else pass_cnt++;
            end
            last_line = i;
            de_cnt = 0;
            hs_cnt = 0;
         end
         if (act.a.de) de_cnt++;
         if (!act.a.hs) hs_cnt++;
      end
      chk_cnt++;
      if (lines !== 4) $display("FAIL line_count got %0d expected 4", lines); else pass_cnt++;
   endtask

   task automatic test_pixdiv_delay();
      obs_t act, ex;
      int last_pix = -1, last_frame = -1, sx10_at = -1, frames = 0, hs_edges = 0;
      logic prev_hs = 1'b1;
      logic [3:0] prev_sx = 4'd0;
      drive_cycle(1'b1, 1'b0, act);
      ex = exp_q.pop_front();
      for (int i = 0; i < 1000; i++) begin
         drive_cycle(1'b0, 1'b1, act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act.b !== ex.b) $display("FAIL pixdiv_b cyc %0d got %h expected %h", i, act.b, ex.b); else pass_cnt++;
         if (act.b.pix) begin
            if (last_pix >= 0) begin
               chk_cnt++;
               if (i - last_pix !== 4) $display("FAIL pix_period got %0d expected 4", i - last_pix); else pass_cnt++;
            end
            last_pix = i;
         end
         if (act.b.frame) begin
            if (last_frame >= 0) begin
               frames++;
               chk_cnt++;
               if (i - last_frame !== 480) $display("FAIL frame_period got %0d expected 480", i - last_frame); else pass_cnt++;
            end
            last_frame = i;
         end
         if (act.b.sx == 4'd10 && prev_sx != 4'd10) sx10_at = i;
         if (act.b.hs && !prev_hs) begin
            hs_edges++;
            chk_cnt++;
            if (sx10_at < 0 || i - sx10_at !== 2) $display("FAIL hsync_delay got %0d expected 2", i - sx10_at); else pass_cnt++;
         end
         prev_hs = act.b.hs;
         prev_sx = act.b.sx;
      end
      chk_cnt++;
      if (frames !== 2 || hs_edges < 10)
         $display("FAIL pixdiv_events got frames=%0d hs_edges=%0d expected 2 and >=10", frames, hs_edges);
      else pass_cnt++;
   endtask

   task automatic test_en_hold();
      obs_t act, ex;
      int pix_seen = 0;
      drive_cycle(1'b1, 1'b0, act);
      ex = exp_q.pop_front();
      for (int i = 0; i < 547; i++) begin
         drive_cycle(1'b0, (i < 477 || i >= 527), act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act !== ex) $display("FAIL hold cyc %0d got %h expected %h", i, act, ex); else pass_cnt++;
         if (i >= 477 && i < 527) begin
            chk_cnt++;
            if ({act.b.sx, act.b.sy} !== {4'd14, 3'd7})
               $display("FAIL hold_counters got sx=%0d sy=%0d expected 14 7", act.b.sx, act.b.sy);
            else pass_cnt++;
            chk_cnt++;
            if ({act.a.pix, act.a.line, act.a.frame, act.b.pix, act.b.line, act.b.frame} !== 6'b0)
               $display("FAIL hold_strobes got %b expected 000000",
                        {act.a.pix, act.a.line, act.a.frame, act.b.pix, act.b.line, act.b.frame});
            else pass_cnt++;
         end
         if (i >= 527 && act.b.pix) begin
            pix_seen++;
            if (pix_seen == 2) begin
               chk_cnt++;
               if ({act.b.frame, act.b.sx, act.b.sy} !== {1'b1, 4'd0, 3'd0})
                  $display("FAIL resume_wrap got frame=%b sx=%0d sy=%0d expected 1 0 0", act.b.frame, act.b.sx, act.b.sy);
               else pass_cnt++;
            end
         end
      end
      chk_cnt++;
      if (pix_seen !== 5) $display("FAIL resume_pix_count got %0d expected 5", pix_seen); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      obs_t act, ex;
      drive_cycle(1'b1, 1'b0, act);
      ex = exp_q.pop_front();
      for (int i = 0; i < 1900; i++) begin
         drive_cycle(1'b0, 1'b1, act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act !== ex) $display("FAIL run cyc %0d got %h expected %h", i, act, ex); else pass_cnt++;
      end
      drive_cycle(1'b1, 1'b1, act);
      ex = exp_q.pop_front();
      chk_cnt++;
      if ({act.a.sx, act.a.sy, act.a.pix} !== {10'd300, 10'd2, 1'b0})
         $display("FAIL pre_reset got sx=%0d sy=%0d pix=%b expected 300 2 0", act.a.sx, act.a.sy, act.a.pix);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 1'b1, act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act !== ex) $display("FAIL post_reset cyc %0d got %h expected %h", i, act, ex); else pass_cnt++;
         if (i == 0) begin
            chk_cnt++;
            if ({act.a.sx, act.a.sy, act.a.hs, act.a.vs, act.a.pix, act.a.line, act.a.frame} !== {20'd0, 5'b11111})
               $display("FAIL restart_a got sx=%0d sy=%0d hs=%b vs=%b stb=%b%b%b expected 0 0 1 1 111",
                        act.a.sx, act.a.sy, act.a.hs, act.a.vs, act.a.pix, act.a.line, act.a.frame);
            else pass_cnt++;
            chk_cnt++;
            if ({act.b.sx, act.b.sy, act.b.hs, act.b.vs} !== 9'b0)
               $display("FAIL restart_b got sx=%0d sy=%0d hs=%b vs=%b expected 0 0 0 0", act.b.sx, act.b.sy, act.b.hs, act.b.vs);
            else pass_cnt++;
         end
         if (i == 3) begin
            chk_cnt++;
            if ({act.b.pix, act.b.frame} !== 2'b11)
               $display("FAIL restart_b_frame got pix=%b frame=%b expected 1 1", act.b.pix, act.b.frame);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t act, ex;
      bit rv, ev;
      drive_cycle(1'b1, 1'b0, act);
      ex = exp_q.pop_front();
      for (int i = 0; i < 400; i++) begin
         rv = ($urandom_range(0, 99) == 0);
         ev = ($urandom_range(0, 3) != 0);
         drive_cycle(rv, ev, act);
         ex = exp_q.pop_front();
         chk_cnt++;
         if (act.a !== ex.a) $display("FAIL random_a cyc %0d got %h expected %h", i, act.a, ex.a); else pass_cnt++;
         chk_cnt++;
         if (act.b !== ex.b) $display("FAIL random_b cyc %0d got %h expected %h", i, act.b, ex.b); else pass_cnt++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      n        = 0;
      chk_cnt  = 0;
      pass_cnt = 0;
      hist_b.push_back('0);
      hist_b.push_back('0);
      @(negedge clk);
      test_reset();
      test_line_timing();
      test_pixdiv_delay();
      test_en_hold();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
